imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream program loader that writes the instruction memory at boot. Sits between a byte source (UART receiver or testbench) and the instruction memory write port. It holds the core in reset while loading and releases it on a verified load. It parses a framed image, packs bytes little-endian into 32-bit words, issues one write per word, and verifies an XOR checksum.

## Interface
- ADDR_WIDTH, 10, word-address width; capacity 2^ADDR_WIDTH words (1024).
- BASE_ADDR, 0, word address of the first written word.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  one-cycle instruction-memory write strobe.
- mem_addr  out  ADDR_WIDTH  word address of the write (memory index = pc >> 2).
- mem_wdata  out  32  write word.
- busy  out  1  load in progress.
- done  out  1  last load completed with a good checksum.
- error  out  1  last load failed (oversize count or bad checksum).
- cpu_hold  out  1  keep core in reset.

## Operation
- Frame: 4-byte word count N (little-endian), then 4·N payload bytes (little-endian words), then 1 checksum byte = XOR of all header and payload bytes.
- Handshake: byte transferred on a cycle with byte_valid && byte_ready. byte_ready=1 only in HDR, DATA and CHK. byte_valid may drop at any time; no timeout.
- States:
  - IDLE: start -> HDR. Clear done, error, checksum, byte and word counters.
  - HDR: accept 4 bytes.
    - After the 4th byte: N > 2^ADDR_WIDTH -> ERR.
    - N == 0 -> CHK.
    - Otherwise -> DATA.
  - DATA: accept bytes. Byte k of a word goes to bits [8k+7:8k]. After each 4th byte, issue a write. After word N-1's write is issued -> CHK.
  - CHK: accept 1 byte. Equal to the running XOR -> DONE, otherwise -> ERR.
  - DONE: done=1, busy=0, cpu_hold=0. start -> HDR (clear done).
  - ERR: error=1, busy=0, cpu_hold=1. start -> HDR (clear error).
- start outside IDLE/DONE/ERR is ignored.
- Writes completed before an error are not undone.
- mem_addr = BASE_ADDR + word index, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
- Checksum is an 8-bit XOR, updated on every accepted byte except the checksum byte itself.

## Timing
- Reset values: state IDLE; byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_hold=0.
- rst mid-load returns to IDLE in the next cycle. A partial word is discarded, and cpu_hold drops.
- All outputs are registered.
- start in cycle T -> busy=1, cpu_hold=1, byte_ready=1 in T+1.
- 4th byte of a word accepted in cycle T -> mem_we=1 in T+1 for exactly one cycle, with mem_addr and mem_wdata valid in the same cycle.
- Back-to-back writes are possible, at most one per 4 cycles.
- Checksum byte accepted in T -> state DONE/ERR in T+1, with done or error set and busy=0 in T+1.
- byte_ready=0 from that cycle onward. The checksum byte is never accepted before the last write has issued.
- Oversize header: 4th header byte accepted in T -> error=1 in T+1. The checksum byte is not consumed.
- Full throughput (byte_valid held high): load time = 4 + 4·N + 1 accepted bytes, plus 1 cycle.

## Test plan
- Two-word load with bytes 02 00 00 00, 93 00 50 00, 13 01 A0 00, 73 -> writes (0, 0x00500093), then (1, 0x00A00113), each one cycle; done=1, error=0, cpu_hold=0.
- Zero-count frame 00 00 00 00, 00 -> no mem_we; done=1 six cycles after start.
- Same two-word frame with checksum 0x74 -> both writes still occur; error=1, done=0, cpu_hold=1.
- Header 01 04 00 00 (N=1025) with ADDR_WIDTH=10 -> no writes; error=1 the cycle after the 4th byte; byte_ready=0.
- Two-word frame with byte_valid toggling every other cycle and start pulsed while busy -> identical writes and final state to the first scenario; the mid-load start has no effect.
- rst asserted after 6 payload bytes -> all outputs at reset values next cycle, no further writes. A following start plus full frame loads correctly from word 0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a framed little-endian byte image,
// writes one 32-bit word per four payload bytes and verifies an XOR checksum.
module imem_loader #(
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH:0]   n_words_q, n_words_d;
  logic [23:0]           shift_q, shift_d;
  logic [7:0]            csum_q, csum_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  cpu_hold_q, cpu_hold_d;

  logic                  accept;
  logic [31:0]           full_word;

  assign accept    = byte_valid && byte_ready_q;
  // Bytes 0..2 of the current word (or header) live in shift_q; byte 3 arrives live.
  assign full_word = {byte_in, shift_q};

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    n_words_d   = n_words_q;
    shift_d     = shift_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          csum_d     = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
        end
      end

      S_HDR, S_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ byte_in;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0:    shift_d[7:0]   = byte_in;
            2'd1:    shift_d[15:8]  = byte_in;
            2'd2:    shift_d[23:16] = byte_in;
            default: ;
          endcase

          if (byte_cnt_q == 2'd3) begin
            if (state_q == S_HDR) begin
              if ({1'b0, full_word} > MAX_WORDS) begin
                state_d = S_ERR;
                error_d = 1'b1;
              end else if (full_word == '0) begin
                state_d = S_CHK;
              end else begin
                n_words_d = full_word[ADDR_WIDTH:0];
                state_d   = S_DATA;
              end
            end else begin
              mem_we_d    = 1'b1;
              mem_addr_d  = BASE_ADDR + word_cnt_q[ADDR_WIDTH-1:0];
              mem_wdata_d = full_word;
              word_cnt_d  = word_cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
              if (word_cnt_d == n_words_q) begin
                state_d = S_CHK;
              end
            end
          end
        end
      end

      S_CHK: begin
        if (accept) begin
          if (byte_in == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Status flags follow the next state so they are registered with it.
    busy_d       = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CHK);
    byte_ready_d = busy_d;
    cpu_hold_d   = busy_d || (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      n_words_q    <= '0;
      shift_q      <= '0;
      csum_q       <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_hold_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      n_words_q    <= n_words_d;
      shift_q      <= shift_d;
      csum_q       <= csum_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random frames against a
// frame-level reference model (expected words, checksum verdict, latencies).
module tb_imem_loader;
  localparam int unsigned AW   = 10;
  localparam longint      CAP  = 1024;
  localparam longint      BASE = 0;
  localparam int          BIG  = 1 << 30;

  logic          clk = 1'b0;
  logic          rst, start, byte_valid, byte_ready;
  logic [7:0]    byte_in;
  logic          mem_we, busy, done, error, cpu_hold;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  typedef logic [7:0] bq_t[$];
  typedef struct {int cyc; logic [7:0] b;} acc_t;
  typedef struct {int cyc; logic [AW-1:0] addr; logic [31:0] data;} wr_t;

  acc_t acc_q[$];
  wr_t  wr_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   start_cyc, end_cyc;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(10'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed handshakes and writes, sampled mid-cycle.
  always @(negedge clk) begin
    if (byte_valid && byte_ready) acc_q.push_back('{cyc, byte_in});
    if (mem_we) wr_q.push_back('{cyc, mem_addr, mem_wdata});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bq_t make_frame(input logic [31:0] n, input bit bad);
    bq_t f;
    logic [7:0]  x  = 8'h00;
    logic [31:0] nn = n;
    for (int i = 0; i < 4; i++) begin
      f.push_back(nn[7:0]);
      nn = nn >> 8;
    end
    if (longint'(n) > CAP) begin
      f.push_back(8'($urandom));
      return f;
    end
    for (longint i = 0; i < 4 * longint'(n); i++) f.push_back(8'($urandom));
    foreach (f[i]) x ^= f[i];
    f.push_back(bad ? ~x : x);
    return f;
  endfunction

  // gap_pct < 0 toggles byte_valid every other cycle.
  task automatic run_frame(input bq_t fr, input int gap_pct, input int stop_after,
                           input bit mid_start);
    int idx = 0;
    int budget;
    bit pulsed = 1'b0;
    bit vld;
    acc_q.delete();
    wr_q.delete();
    end_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1;
    byte_valid = 1'b0;
    start_cyc = cyc;
    @(posedge clk); #1;
    budget = 10 * fr.size() + 50;
    for (int k = 0; k < budget; k++) begin
      start = 1'b0;
      if (mid_start && !pulsed && idx == 6) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      if (gap_pct < 0) vld = (k % 2 == 0);
      else vld = ($urandom_range(99) >= gap_pct);
      if (idx < fr.size() && idx < stop_after && vld) begin
        byte_valid = 1'b1;
        byte_in = fr[idx];
      end else begin
        byte_valid = 1'b0;
        byte_in = 8'($urandom);
      end
      @(negedge clk);
      if (k == 0) begin
        check("busy_after_start", busy, 1);
        check("hold_after_start", cpu_hold, 1);
        check("ready_after_start", byte_ready, 1);
      end
      if (byte_valid && byte_ready) idx++;
      if (idx >= stop_after) break;
      if (!busy) begin
        end_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    start = 1'b0;
    if (stop_after >= fr.size()) check("load_finished", end_cyc >= 0, 1);
  endtask

  task automatic verify(input bq_t fr, input bit timed);
    longint     n;
    int         cons, nw;
    logic [7:0] x;
    bit         over, good;
    n    = longint'({fr[3], fr[2], fr[1], fr[0]});
    over = n > CAP;
    cons = over ? 4 : 4 + 4 * int'(n) + 1;
    nw   = over ? 0 : int'(n);
    check("accepted_count", acc_q.size(), cons);
    for (int i = 0; i < cons && i < acc_q.size(); i++) check("accepted_byte", acc_q[i].b, fr[i]);
    check("write_count", wr_q.size(), nw);
    for (int i = 0; i < nw && i < wr_q.size(); i++) begin
      check("wr_addr", wr_q[i].addr, (BASE + i) % CAP);
      check("wr_data", wr_q[i].data, {fr[4*i+7], fr[4*i+6], fr[4*i+5], fr[4*i+4]});
      if (4 * i + 7 < acc_q.size()) check("wr_cycle", wr_q[i].cyc, acc_q[4*i+7].cyc + 1);
    end
    x = 8'h00;
    if (!over) for (int i = 0; i < cons - 1; i++) x ^= fr[i];
    good = !over && (x == fr[cons-1]);
    check("done", done, good);
    check("error", error, !good);
    check("cpu_hold", cpu_hold, !good);
    check("busy_end", busy, 0);
    check("ready_end", byte_ready, 0);
    if (acc_q.size() >= cons) check("end_cycle", end_cyc, acc_q[cons-1].cyc + 1);
    if (timed) check("load_time", end_cyc - start_cyc, cons + 1);
  endtask

  initial begin
    bq_t         fr;
    logic [31:0] n;
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", byte_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_hold", cpu_hold, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_hold", cpu_hold, 0);

    // Two-word good frame.
    fr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
           8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
    run_frame(fr, 0, BIG, 1'b0);
    verify(fr, 1'b1);
    if (wr_q.size() == 2) begin
      check("two_word_w0", wr_q[0].data, 32'h00500093);
      check("two_word_w1", wr_q[1].data, 32'h00A00113);
    end

    // Zero-count frame.
    fr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fr, 0, BIG, 1'b0);
    verify(fr, 1'b1);

    // Bad checksum.
    fr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
           8'h13, 8'h01, 8'hA0, 8'h00, 8'h74};
    run_frame(fr, 0, BIG, 1'b0);
    verify(fr, 1'b1);

    // Oversize header, trailing byte must stay unconsumed.
    fr = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h55};
    run_frame(fr, 0, BIG, 1'b0);
    verify(fr, 1'b1);

    // Toggling valid plus a start pulse while busy.
    fr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
           8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
    run_frame(fr, -1, BIG, 1'b1);
    verify(fr, 1'b0);

    // Reset after six payload bytes.
    run_frame(fr, 0, 10, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", byte_ready, 0);
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_wdata", mem_wdata, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_hold", cpu_hold, 0);
    repeat (5) @(negedge clk);
    check("mid_rst_writes", wr_q.size(), 1);
    if (wr_q.size() >= 1) check("mid_rst_w0", wr_q[0].data, {fr[7], fr[6], fr[5], fr[4]});
    run_frame(fr, 0, BIG, 1'b0);
    verify(fr, 1'b1);

    // Random frames.
    for (int t = 0; t < 14; t++) begin
      int gap;
      if ($urandom_range(9) == 0) n = 32'($urandom_range(1025, 70000));
      else n = 32'($urandom_range(0, 9));
      gap = ($urandom_range(1) == 0) ? 0 : 35;
      fr = make_frame(n, $urandom_range(3) == 0);
      run_frame(fr, gap, BIG, 1'b0);
      verify(fr, gap == 0);
    end

    // Maximum capacity.
    fr = make_frame(32'd1024, 1'b0);
    run_frame(fr, 0, BIG, 1'b0);
    verify(fr, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
